mat_mem_responder: RTL

//  Word-addressed memory slave that answers the matrix multiplier's memory-transaction

---
 rtl/mat_mem_responder.sv | 93 +++++++++
 1 files changed

// File: rtl/mat_mem_responder.sv
// mat_mem_responder: latency-programmable word memory slave for the matrix multiplier handshake; MAT_MEM_CLEAR_EN adds a post-reset zero-fill
module mat_mem_responder #(
  parameter int AW = 6,
  parameter int DW = 32,
  parameter int LATENCY = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_we,
  input  logic [31:0]   i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic          o_done,
  output logic          o_busy,
  output logic          o_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP, CLEAR} state_t;
`ifdef MAT_MEM_CLEAR_EN
  localparam state_t START = CLEAR;
  localparam logic BUSY0 = 1'b1;
  logic [AW-1:0] ccnt;
`else
  localparam state_t START = IDLE;
  localparam logic BUSY0 = 1'b0;
`endif
  state_t state;
  logic [3:0] cnt;
  logic l_we;
  logic [31:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic [DW-1:0] mem [2**AW];
  logic [31:0] a_addr;
  logic a_we, a_err, l_err, to_resp;
  // the response fields come straight from the inputs when LATENCY==1 skips WAIT
  assign a_addr = state == IDLE ? i_addr : l_addr;
  assign a_we = state == IDLE ? i_we : l_we;
  assign a_err = (|a_addr[1:0]) || (|a_addr[31:AW+2]);
  assign l_err = (|l_addr[1:0]) || (|l_addr[31:AW+2]);
  assign to_resp = state == IDLE ? (i_start && LATENCY == 1) : (state == WAIT && cnt == 4'd1);
  // handshake FSM; o_rdata/o_err/o_done are registered on entry to RESP so they line up with the done cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= START;
      cnt <= '0;
      o_done <= 1'b0;
      o_busy <= BUSY0;
      o_err <= 1'b0;
      o_rdata <= '0;
`ifdef MAT_MEM_CLEAR_EN
      ccnt <= '0;
`endif
    end else begin
      o_done <= to_resp;
      o_err <= to_resp && a_err;
      if (to_resp && !a_we && !a_err) o_rdata <= mem[a_addr[AW+1:2]];
      case (state)
        IDLE: if (i_start) begin
          l_we <= i_we;
          l_addr <= i_addr;
          l_wdata <= i_wdata;
          cnt <= 4'(LATENCY - 1);
          state <= LATENCY == 1 ? RESP : WAIT;
          o_busy <= 1'b1;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          state <= cnt == 4'd1 ? RESP : WAIT;
        end
        RESP: begin
          state <= IDLE;
          o_busy <= 1'b0;
        end
        default: begin
`ifdef MAT_MEM_CLEAR_EN
          ccnt <= ccnt + 1'b1;
          state <= &ccnt ? IDLE : CLEAR;
          o_busy <= ~&ccnt;
`else
          state <= IDLE;
`endif
        end
      endcase
    end
  end
  // storage: writes commit at the RESP edge unless reset drops them or the address faulted
  always_ff @(posedge clk) begin
`ifdef MAT_MEM_CLEAR_EN
    if (!rst && state == CLEAR) mem[ccnt] <= '0;
`endif
    if (!rst && state == RESP && l_we && !l_err) mem[l_addr[AW+1:2]] <= l_wdata;
  end
endmodule
